// File: rtl/bus_rd_fifo_if.sv
// Handshake bundle between a CPU mailbox read FIFO and its producer and CPU-side logic.
interface bus_rd_fifo_if #(
    parameter int W  = 8,
    parameter int AW = 2
);
    logic          push;
    logic [W-1:0]  push_d;
    logic          push_rdy;
    logic          rd;
    logic [W-1:0]  q;
    logic          irq;
    logic [AW:0]   count;
    logic          ovf;
    logic          unf;
    logic          clr_flags;

    // Producer / CPU side: drives requests and observes the FIFO state
    modport master (
        output push, push_d, rd, clr_flags,
        input  push_rdy, q, irq, count, ovf, unf
    );

    // FIFO side
    modport slave (
        input  push, push_d, rd, clr_flags,
        output push_rdy, q, irq, count, ovf, unf
    );
endinterface

// File: rtl/bus_rd_fifo.sv
// Read side of a CPU mailbox: small FIFO filled by a valid/ready producer and
// drained by a CPU read strobe. Each strobe pulse pops one entry at its falling
// edge, so q stays stable for the whole CPU read cycle.
module bus_rd_fifo #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic           clk,
    input  logic           rst,
    bus_rd_fifo_if.slave   bus
);
    localparam int          DEPTH = 2 ** AW;
    localparam logic [AW:0] FULL  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE   = (AW + 1)'(1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [W-1:0]  data_q, data_d;
    logic          irq_q, irq_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          rd_prev_q, rd_prev_d;
    logic          pop_req, push_ok, pop_ok, full, empty;

    // Next-state: strobe fall detection, pointer/count update, head data and flags
    always_comb begin
        rd_prev_d = bus.rd;
        full      = (count_q == FULL);
        empty     = (count_q == '0);
        pop_req   = rd_prev_q & ~bus.rd;
        push_ok   = bus.push & ~full;
        pop_ok    = pop_req & ~empty;

        wr_ptr_d  = wr_ptr_q + AW'(push_ok);
        rd_ptr_d  = rd_ptr_q + AW'(pop_ok);

        count_d   = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + ONE;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - ONE;
        end

        // New head equals the slot being written only when that entry becomes
        // the sole/first valid one, so bypass the memory in that case.
        data_d = data_q;
        if (count_d != '0) begin
            if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
                data_d = bus.push_d;
            end else begin
                data_d = mem_q[rd_ptr_d];
            end
        end

        irq_d = (count_d != '0);

        // A set event in the same cycle takes priority over the clear
        ovf_d = (bus.push & full)  | (ovf_q & ~bus.clr_flags);
        unf_d = (pop_req  & empty) | (unf_q & ~bus.clr_flags);
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            data_q    <= '0;
            irq_q     <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            rd_prev_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            data_q    <= data_d;
            irq_q     <= irq_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            rd_prev_q <= rd_prev_d;
        end
    end

    // Storage array; contents are don't-care after reset since pointers restart
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_ptr_q] <= bus.push_d;
        end
    end

    assign bus.push_rdy = ~full;
    assign bus.q        = data_q;
    assign bus.irq      = irq_q;
    assign bus.count    = count_q;
    assign bus.ovf      = ovf_q;
    assign bus.unf      = unf_q;
endmodule

// File: tb/tb_bus_rd_fifo.sv
// Testbench for bus_rd_fifo: directed scenarios followed by random traffic,
// all compared against a queue-based reference model.
module tb_bus_rd_fifo;
    localparam int W     = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 2 ** AW;

    logic clk = 1'b0;
    logic rst = 1'b0;

    bus_rd_fifo_if #(.W(W), .AW(AW)) bif ();

    bus_rd_fifo #(.W(W), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [W-1:0] mq[$];
    logic [W-1:0] m_q;
    logic         m_ovf;
    logic         m_unf;
    logic         m_rd_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".count"}, 32'(bif.count), 32'(mq.size()));
        chk({tag, ".irq"}, 32'(bif.irq), 32'(mq.size() != 0));
        chk({tag, ".q"}, 32'(bif.q), 32'(m_q));
        chk({tag, ".push_rdy"}, 32'(bif.push_rdy), 32'(mq.size() != DEPTH));
        chk({tag, ".ovf"}, 32'(bif.ovf), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(bif.unf), 32'(m_unf));
    endtask

    // Apply one cycle of inputs, advance the model, then compare after the edge
    task automatic step(input logic p, input logic [W-1:0] d, input logic r,
                        input logic c, input logic rs, input string tag);
        logic pop_req, was_full, was_empty;
        bif.push      = p;
        bif.push_d    = d;
        bif.rd        = r;
        bif.clr_flags = c;
        rst           = rs;
        if (rs) begin
            mq.delete();
            m_q       = '0;
            m_ovf     = 1'b0;
            m_unf     = 1'b0;
            m_rd_prev = 1'b0;
        end else begin
            pop_req   = m_rd_prev && !r;
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            m_ovf     = (p && was_full) ? 1'b1 : (c ? 1'b0 : m_ovf);
            m_unf     = (pop_req && was_empty) ? 1'b1 : (c ? 1'b0 : m_unf);
            if (pop_req && !was_empty) void'(mq.pop_front());
            if (p && !was_full) mq.push_back(d);
            if (mq.size() != 0) m_q = mq[0];
            m_rd_prev = r;
        end
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    task automatic rd_pulse(input string tag);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, tag);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        logic [W-1:0] dat;
        logic         rd_r;
        bif.push      = 1'b0;
        bif.push_d    = '0;
        bif.rd        = 1'b0;
        bif.clr_flags = 1'b0;
        m_q = '0; m_ovf = 1'b0; m_unf = 1'b0; m_rd_prev = 1'b0;

        // 1: reset with rd low, then idle
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, "t1_rst");
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, "t1_rst");
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0, "t1_idle");
        chk("t1_q_zero", 32'(bif.q), 32'h0);

        // 2: single push, long read strobe
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, "t2_push");
        chk("t2_q", 32'(bif.q), 32'h11);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, "t2_rdhi");
        chk("t2_cnt_hold", 32'(bif.count), 32'd1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, "t2_fall");
        chk("t2_cnt_after", 32'(bif.count), 32'd0);
        chk("t2_q_stale", 32'(bif.q), 32'h11);

        // 3: overfill, then drain in order
        for (int i = 0; i < 5; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0, "t3_fill");
        chk("t3_ovf", 32'(bif.ovf), 32'd1);
        chk("t3_full", 32'(bif.push_rdy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("t3_head", 32'(bif.q), 32'hA0 + 32'(i));
            rd_pulse("t3_drain");
        end
        chk("t3_empty", 32'(bif.count), 32'd0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, "t3_clr");

        // 4: simultaneous push and pop at count 2, across pointer wrap
        step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, "t4_push");
        step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, "t4_push");
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, "t4_rdhi");
        step(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, "t4_both");
        chk("t4_cnt", 32'(bif.count), 32'd2);
        chk("t4_q", 32'(bif.q), 32'h02);
        rd_pulse("t4_rd1");
        chk("t4_q3", 32'(bif.q), 32'h03);
        rd_pulse("t4_rd2");

        // 5: underflow and flag-clear priority
        rd_pulse("t5_unf");
        chk("t5_unf", 32'(bif.unf), 32'd1);
        chk("t5_q", 32'(bif.q), 32'h03);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, "t5_rdhi");
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, "t5_clr_pop");
        chk("t5_unf_kept", 32'(bif.unf), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, "t5_clr");
        chk("t5_unf_clr", 32'(bif.unf), 32'd0);

        // 6: reset mid-operation with rd high
        for (int i = 0; i < 3; i++) step(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0, 1'b0, "t6_fill");
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, "t6_rdhi");
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, "t6_rst");
        chk("t6_cnt", 32'(bif.count), 32'd0);
        chk("t6_q", 32'(bif.q), 32'h0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, "t6_rdhi2");
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, "t6_fall");
        chk("t6_unf", 32'(bif.unf), 32'd1);
        step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, "t6_push");
        chk("t6_q_new", 32'(bif.q), 32'h77);

        // Random traffic
        rd_r = 1'b0;
        for (int i = 0; i < 400; i++) begin
            dat = W'($urandom);
            if ($urandom_range(0, 2) == 0) rd_r = ~rd_r;
            step(1'($urandom_range(0, 1)), dat, rd_r,
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
